// File: rtl/vending_customer.sv
// Customer-side purchase driver for the vending machine coin/item interface.
// Optional watchdog on the wait states: define VENDING_CUSTOMER_TIMEOUT_EN.
module vending_customer #(
    parameter logic [3:0]  W5_INIT = 4'd3,
    parameter logic [3:0]  W1_INIT = 4'd3,
    parameter int unsigned COST_A  = 8,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       req_item,
    input  logic [1:0] req_coin5,
    input  logic [1:0] req_coin1,
    input  logic [1:0] serviceTypeIn,
    input  logic [2:0] coinInNTD_5,
    input  logic [2:0] coinInNTD_1,
    input  logic       itemTypeIn,
    output logic [1:0] coinOutNTD_5,
    output logic [1:0] coinOutNTD_1,
    output logic       itemTypeOut,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       reject,
    output logic [3:0] wallet5,
    output logic [3:0] wallet1,
    output logic [3:0] items_got
);

    localparam logic [1:0] SVC_OFF  = 2'b00;
    localparam logic [1:0] SVC_ON   = 2'b01;
    localparam logic [1:0] SVC_BUSY = 2'b10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_ON   = 3'd1,
        OFFER     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_OFF  = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t     state_r;
    logic [1:0] coin5_r;
    logic [1:0] coin1_r;
    logic       item_r;
    logic [4:0] amount_r;

    logic [4:0] amount_s;
    logic [5:0] returned_s;
    logic [5:0] expected_s;
    logic       change_bad_s;
    logic       req_ok_s;
    logic       timeout_s;

    function automatic logic [3:0] sat_add(input logic [3:0] w, input logic [2:0] c);
        logic [4:0] sum;
        sum = {1'b0, w} + {2'b00, c};
        if (sum > 5'd15) begin
            sat_add = 4'd15;
        end else begin
            sat_add = sum[3:0];
        end
    endfunction

    // Request validation and change arithmetic for the current cycle.
    always_comb begin
        amount_s   = (5'(req_coin5) * 5'd5) + 5'(req_coin1);
        returned_s = (6'(coinInNTD_5) * 6'd5) + 6'(coinInNTD_1);
        req_ok_s   = req_item && ({2'b00, req_coin5} <= wallet5) && ({2'b00, req_coin1} <= wallet1);
        if (itemTypeIn == 1'b1) begin
            expected_s   = 6'(amount_r) - 6'(COST_A);
            change_bad_s = (amount_r < 5'(COST_A)) || (returned_s != expected_s);
        end else begin
            expected_s   = 6'(amount_r);
            change_bad_s = (returned_s != expected_s);
        end
    end

`ifdef VENDING_CUSTOMER_TIMEOUT_EN
    localparam logic [5:0] TMO_LAST = 6'(TIMEOUT - 1);

    logic [5:0] tmo_r;
    logic       stay_wait_s;

    // A wait state is "parked" when its exit condition is absent this cycle.
    always_comb begin
        case (state_r)
            WAIT_ON:   stay_wait_s = (serviceTypeIn != SVC_ON);
            WAIT_BUSY: stay_wait_s = (serviceTypeIn != SVC_BUSY) && (serviceTypeIn != SVC_OFF);
            WAIT_OFF:  stay_wait_s = (serviceTypeIn != SVC_OFF);
            default:   stay_wait_s = 1'b0;
        endcase
        timeout_s = stay_wait_s && (tmo_r == TMO_LAST);
    end

    // Counter is zero whenever a state is (re)entered, so it times each wait separately.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_r <= 6'd0;
        end else if (stay_wait_s && !timeout_s) begin
            tmo_r <= tmo_r + 6'd1;
        end else begin
            tmo_r <= 6'd0;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Purchase FSM with registered outputs and wallet bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            coin5_r      <= 2'd0;
            coin1_r      <= 2'd0;
            item_r       <= 1'b0;
            amount_r     <= 5'd0;
            coinOutNTD_5 <= 2'd0;
            coinOutNTD_1 <= 2'd0;
            itemTypeOut  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            reject       <= 1'b0;
            wallet5      <= W5_INIT;
            wallet1      <= W1_INIT;
            items_got    <= 4'd0;
        end else begin
            done         <= 1'b0;
            reject       <= 1'b0;
            coinOutNTD_5 <= 2'd0;
            coinOutNTD_1 <= 2'd0;
            itemTypeOut  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start && req_ok_s) begin
                        coin5_r  <= req_coin5;
                        coin1_r  <= req_coin1;
                        item_r   <= req_item;
                        amount_r <= amount_s;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        state_r  <= WAIT_ON;
                    end else if (start) begin
                        reject <= 1'b1;
                    end
                end
                WAIT_ON: begin
                    if (serviceTypeIn == SVC_ON) begin
                        coinOutNTD_5 <= coin5_r;
                        coinOutNTD_1 <= coin1_r;
                        itemTypeOut  <= item_r;
                        wallet5      <= wallet5 - {2'b00, coin5_r};
                        wallet1      <= wallet1 - {2'b00, coin1_r};
                        state_r      <= OFFER;
                    end else if (timeout_s) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end
                end
                OFFER: begin
                    state_r <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (serviceTypeIn == SVC_BUSY) begin
                        state_r <= WAIT_OFF;
                    end else if ((serviceTypeIn == SVC_OFF) || timeout_s) begin
                        // Machine skipped BUSY (or never answered): abandon with error.
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end
                end
                WAIT_OFF: begin
                    if (serviceTypeIn == SVC_OFF) begin
                        err       <= err | change_bad_s;
                        wallet5   <= sat_add(wallet5, coinInNTD_5);
                        wallet1   <= sat_add(wallet1, coinInNTD_1);
                        items_got <= items_got + {3'b000, itemTypeIn};
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_r   <= DONE;
                    end else if (timeout_s) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vending_customer.sv
// Directed bench for vending_customer: a vector table of whole purchases plus
// hand-written sequences for protocol violation, hang/timeout and mid-purchase reset.
module tb_vending_customer;

    localparam logic [1:0] SVC_OFF  = 2'b00;
    localparam logic [1:0] SVC_ON   = 2'b01;
    localparam logic [1:0] SVC_BUSY = 2'b10;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       req_item;
    logic [1:0] req_coin5;
    logic [1:0] req_coin1;
    logic [1:0] serviceTypeIn;
    logic [2:0] coinInNTD_5;
    logic [2:0] coinInNTD_1;
    logic       itemTypeIn;
    logic [1:0] coinOutNTD_5;
    logic [1:0] coinOutNTD_1;
    logic       itemTypeOut;
    logic       busy;
    logic       done;
    logic       err;
    logic       reject;
    logic [3:0] wallet5;
    logic [3:0] wallet1;
    logic [3:0] items_got;

    int checks = 0;
    int errors = 0;
    int cur    = -1;

    typedef struct {
        logic       item;
        logic [1:0] c5;
        logic [1:0] c1;
        logic [2:0] r5;
        logic [2:0] r1;
        logic       ritem;
        logic       rej;
        logic       err;
        logic [3:0] w5;
        logic [3:0] w1;
        logic [3:0] items;
    } vec_t;

    vec_t vecs[13];

    vending_customer dut (
        .clk(clk), .reset(reset), .start(start), .req_item(req_item),
        .req_coin5(req_coin5), .req_coin1(req_coin1), .serviceTypeIn(serviceTypeIn),
        .coinInNTD_5(coinInNTD_5), .coinInNTD_1(coinInNTD_1), .itemTypeIn(itemTypeIn),
        .coinOutNTD_5(coinOutNTD_5), .coinOutNTD_1(coinOutNTD_1), .itemTypeOut(itemTypeOut),
        .busy(busy), .done(done), .err(err), .reject(reject),
        .wallet5(wallet5), .wallet1(wallet1), .items_got(items_got)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL [step %0d] %s: got %0d, expected %0d", cur, name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic item, input logic [1:0] c5, input logic [1:0] c1);
        start     = 1'b1;
        req_item  = item;
        req_coin5 = c5;
        req_coin1 = c1;
        tick();
        start = 1'b0;
    endtask

    // Drive ON and wait (bounded) until the OFFER cycle is visible.
    task automatic go_offer();
        int n;
        serviceTypeIn = SVC_ON;
        n = 0;
        do begin
            tick();
            n++;
        end while (itemTypeOut !== 1'b1 && n < 10);
        check("offer_seen", int'(itemTypeOut), 1);
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check("done_seen", int'(done), 1);
    endtask

    initial begin
        int n;
        //              item  c5    c1    r5    r1    ritem rej   err   w5     w1     items
        vecs[0]  = '{1'b1, 2'd1, 2'd1, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 4'd3,  4'd3,  4'd0};
        vecs[1]  = '{1'b1, 2'd2, 2'd0, 3'd0, 3'd1, 1'b1, 1'b0, 1'b1, 4'd1,  4'd4,  4'd1};
        vecs[2]  = '{1'b1, 2'd1, 2'd3, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd1,  4'd2};
        vecs[3]  = '{1'b0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd1,  4'd2};
        vecs[4]  = '{1'b1, 2'd3, 2'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd1,  4'd2};
        vecs[5]  = '{1'b1, 2'd0, 2'd2, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd1,  4'd2};
        vecs[6]  = '{1'b1, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd1,  4'd2};
        vecs[7]  = '{1'b1, 2'd0, 2'd1, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd1,  4'd2};
        vecs[8]  = '{1'b1, 2'd0, 2'd1, 3'd7, 3'd7, 1'b0, 1'b0, 1'b1, 4'd7,  4'd7,  4'd2};
        vecs[9]  = '{1'b1, 2'd0, 2'd1, 3'd7, 3'd7, 1'b0, 1'b0, 1'b1, 4'd14, 4'd13, 4'd2};
        vecs[10] = '{1'b1, 2'd0, 2'd1, 3'd7, 3'd7, 1'b0, 1'b0, 1'b1, 4'd15, 4'd15, 4'd2};
        vecs[11] = '{1'b1, 2'd0, 2'd1, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 4'd15, 4'd14, 4'd3};
        vecs[12] = '{1'b1, 2'd3, 2'd3, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0, 4'd14, 4'd11, 4'd4};

        reset = 1'b1; start = 1'b0; req_item = 1'b0; req_coin5 = 2'd0; req_coin1 = 2'd0;
        serviceTypeIn = SVC_OFF; coinInNTD_5 = 3'd0; coinInNTD_1 = 3'd0; itemTypeIn = 1'b0;
        tick();
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_reject", int'(reject), 0);
        check("rst_coin5", int'(coinOutNTD_5), 0);
        check("rst_item_out", int'(itemTypeOut), 0);
        check("rst_wallet5", int'(wallet5), 3);
        check("rst_wallet1", int'(wallet1), 3);
        check("rst_items", int'(items_got), 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 13; i++) begin
            cur = i;
            do_start(vecs[i].item, vecs[i].c5, vecs[i].c1);
            if (vecs[i].rej) begin
                check("reject", int'(reject), 1);
                check("reject_busy", int'(busy), 0);
                check("reject_coin5", int'(coinOutNTD_5), 0);
                check("reject_coin1", int'(coinOutNTD_1), 0);
                tick();
                check("reject_pulse", int'(reject), 0);
                check("reject_wallet5", int'(wallet5), int'(vecs[i].w5));
                check("reject_wallet1", int'(wallet1), int'(vecs[i].w1));
            end else begin
                check("accept_busy", int'(busy), 1);
                check("accept_reject", int'(reject), 0);
                check("accept_err_clear", int'(err), 0);
                go_offer();
                check("offer_coin5", int'(coinOutNTD_5), int'(vecs[i].c5));
                check("offer_coin1", int'(coinOutNTD_1), int'(vecs[i].c1));
                serviceTypeIn = SVC_BUSY;
                tick();
                check("offer_len_coin5", int'(coinOutNTD_5), 0);
                check("offer_len_item", int'(itemTypeOut), 0);
                tick();
                serviceTypeIn = SVC_OFF;
                coinInNTD_5   = vecs[i].r5;
                coinInNTD_1   = vecs[i].r1;
                itemTypeIn    = vecs[i].ritem;
                wait_done(10);
                check("done_busy", int'(busy), 0);
                check("done_err", int'(err), int'(vecs[i].err));
                check("done_wallet5", int'(wallet5), int'(vecs[i].w5));
                check("done_wallet1", int'(wallet1), int'(vecs[i].w1));
                check("done_items", int'(items_got), int'(vecs[i].items));
                coinInNTD_5 = 3'd0; coinInNTD_1 = 3'd0; itemTypeIn = 1'b0;
                tick();
                check("done_pulse", int'(done), 0);
                check("err_sticky", int'(err), int'(vecs[i].err));
            end
        end

        // Machine drops straight back to OFF without passing through BUSY.
        cur = 100;
        do_start(1'b1, 2'd0, 2'd0);
        go_offer();
        serviceTypeIn = SVC_OFF;
        wait_done(10);
        check("proto_err", int'(err), 1);
        check("proto_busy", int'(busy), 0);
        tick();

        // Machine stays BUSY for 40 cycles after the offer.
        cur = 101;
        do_start(1'b1, 2'd0, 2'd0);
        go_offer();
        serviceTypeIn = SVC_BUSY;
        n = 0;
        do begin
            tick();
            n++;
        end while (done !== 1'b1 && n < 40);
`ifdef VENDING_CUSTOMER_TIMEOUT_EN
        check("tmo_latency", n, 34);
        check("tmo_err", int'(err), 1);
        check("tmo_busy", int'(busy), 0);
`else
        check("hang_busy", int'(busy), 1);
        check("hang_done", int'(done), 0);
`endif
        serviceTypeIn = SVC_OFF;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // Reset while waiting for OFF abandons the purchase and reloads the wallet.
        cur = 102;
        do_start(1'b1, 2'd1, 2'd1);
        go_offer();
        check("mid_wallet5", int'(wallet5), 2);
        serviceTypeIn = SVC_BUSY;
        tick();
        tick();
        check("mid_busy", int'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        serviceTypeIn = SVC_OFF;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_err", int'(err), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_wallet5", int'(wallet5), 3);
        check("mid_rst_wallet1", int'(wallet1), 3);
        check("mid_rst_items", int'(items_got), 0);
        tick();
        check("mid_idle_done", int'(done), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vending_customer.md
Name: vending_customer

Overview:
- Purchase initiator for the vending machine: the customer-side end of the coin/item interface.
- Holds a wallet of NTD_5/NTD_1 coins and inserts coins plus an item request when the machine is in SERVICE_ON.
- Follows the machine through BUSY to OFF, collects the change and the item, and checks that change + item cost equals the money inserted.
- Serves as an environment/driver block for verification and system demos.

Parameters:
- W5_INIT, 3, wallet NTD_5 count after reset (0..15)
- W1_INIT, 3, wallet NTD_1 count after reset (0..15)
- COST_A, 8, price of ITEM_A in NTD, used by the change check
- TIMEOUT, 32, watchdog limit in cycles per wait state (optional feature only)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle purchase request
- req_item  in  1  item to request (1 = ITEM_A)
- req_coin5  in  2  NTD_5 coins to insert
- req_coin1  in  2  NTD_1 coins to insert
- serviceTypeIn  in  2  machine state (00 OFF, 01 ON, 10 BUSY)
- coinInNTD_5  in  3  change NTD_5 count from machine
- coinInNTD_1  in  3  change NTD_1 count from machine
- itemTypeIn  in  1  item delivered by machine
- coinOutNTD_5  out  2  NTD_5 coins inserted into machine
- coinOutNTD_1  out  2  NTD_1 coins inserted into machine
- itemTypeOut  out  1  item request to machine
- busy  out  1  purchase in progress
- done  out  1  one-cycle pulse: purchase finished
- err  out  1  sticky change mismatch/timeout flag; cleared by the next accepted start
- reject  out  1  one-cycle pulse: start refused
- wallet5  out  4  current wallet NTD_5
- wallet1  out  4  current wallet NTD_1
- items_got  out  4  count of ITEM_A received (wraps at 15 -> 0)

Behaviour:
- Reset: state IDLE; coinOut*=0, itemTypeOut=0, busy=0, done=0, err=0, reject=0, wallet5=W5_INIT, wallet1=W1_INIT, items_got=0. A reset mid-purchase abandons the purchase; coins already inserted are lost and the wallet reloads.
- States: IDLE, WAIT_ON, OFFER, WAIT_BUSY, WAIT_OFF, DONE.
- IDLE:
  - start=1 with req_item=0, or req_coin5>wallet5, or req_coin1>wallet1 -> reject=1 for one cycle, stay IDLE.
  - Otherwise latch the request and amount = 5*req_coin5 + req_coin1 (5-bit, max 18); clear err; busy=1; go WAIT_ON.
  - start while busy is ignored.
- WAIT_ON: when serviceTypeIn==ON, go OFFER.
- OFFER (exactly one cycle):
  - Drive coinOut*=latched counts and itemTypeOut=req_item.
  - Debit the wallet the same cycle.
  - Next state WAIT_BUSY; coinOut*/itemTypeOut return to 0 next cycle.
- WAIT_BUSY: when serviceTypeIn==BUSY, go WAIT_OFF. Observing OFF here counts as a protocol violation: set err, go DONE.
- WAIT_OFF: in the first cycle serviceTypeIn==OFF, sample the change and item.
  - returned = 5*coinInNTD_5 + coinInNTD_1, computed in 6 bits (max 42).
  - expected = amount - (itemTypeIn ? COST_A : 0).
  - If itemTypeIn=1 and amount<COST_A, or returned != expected, set err.
  - Credit the wallet, saturating each count at 15. items_got += itemTypeIn.
  - Go DONE.
- DONE: done=1 for one cycle, busy=0, go IDLE. A new start is accepted the following cycle.
- Purchases with zero coins are legal; the machine returns item NONE with change 0.
- Outputs are registered; all latency is counted from the start cycle (cycle 0).

Optional Feature:
- Macro: VENDING_CUSTOMER_TIMEOUT_EN.
- Defined:
  - A 6-bit counter clears on each state entry and increments while in WAIT_ON, WAIT_BUSY or WAIT_OFF.
  - When it reaches TIMEOUT, set err and go DONE. The wallet is not refunded.
- Undefined: no counter; the FSM waits indefinitely.

Test Plan:
- Pay 2x NTD_5 for ITEM_A; machine returns coinInNTD_1=2, item=1 -> done pulses, err=0, wallet5=1, wallet1=5, items_got=1.
- Pay 1x NTD_5 + 1x NTD_1 for ITEM_A (6 < 8); machine returns 5=1, 1=1, item=0 -> err=0, wallet5=3, wallet1=3, items_got=0.
- start with req_item=0; then start with req_coin5=3 and wallet5=1 -> reject pulses each time, busy stays 0, coinOut* stay 0.
- Pay 10 for ITEM_A; bench returns coinInNTD_1=1 only -> err=1 sticky through DONE; cleared on the next accepted start.
- With the macro defined, hold serviceTypeIn=BUSY for 40 cycles after OFFER -> err=1 and done exactly TIMEOUT=32 cycles after entering WAIT_OFF. Without the macro, busy stays 1.
- Assert reset during WAIT_OFF -> next cycle IDLE, wallet5=3, wallet1=3, busy=0, err=0.
